// File: rtl/ddr3_burst_arbiter.sv
`timescale 1ns/1ps
// ddr3_burst_arbiter: shares the MIG app interface between one write and one
// read burst requester. A grant runs a burst of app commands from a start
// address, counts returned read beats and pulses a done strobe at the end.
module ddr3_burst_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 8
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_ack,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              rd_urgent,
  output logic              rd_ack,
  output logic              rd_done,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic              rfifo_wren,
  output logic              busy
);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BURST,
    S_RD_BURST,
    S_RD_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cmd_cnt_q;
  logic [LEN_W:0]    beat_cnt_q;
  logic              last_rd_q;   // last served requester was the read side
  logic              is_rd_q;     // direction of the burst in flight
  logic              app_en_q;
  logic [2:0]        app_cmd_q;
  logic              wdf_q;
  logic              wr_done_q;
  logic              rd_done_q;

  logic              arb_ok;
  logic              grant_rd_c;
  logic              grant_wr_c;
  logic              wr_accept_c;
  logic              rd_accept_c;
  logic              last_cmd_c;
  logic              in_rd_c;
  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  cmd_cnt_d;
  logic [LEN_W:0]    beat_d;
  logic              beats_done_c;

  // Arbitration and per-cycle datapath helpers
  always_comb begin
    arb_ok       = (state_q == S_IDLE) && init_calib_complete;
    // Urgent read first, then round-robin on a tie, then whoever is asking.
    grant_rd_c   = arb_ok && rd_req &&
                   (rd_urgent || !wr_req || !last_rd_q);
    grant_wr_c   = arb_ok && wr_req && !grant_rd_c;
    wr_accept_c  = app_rdy && app_wdf_rdy;
    rd_accept_c  = app_rdy;
    last_cmd_c   = (cmd_cnt_q == (len_q - LEN_W'(1)));
    in_rd_c      = (state_q == S_RD_BURST) || (state_q == S_RD_DRAIN);
    addr_d       = addr_q + ADDR_W'(ADDR_STEP);
    cmd_cnt_d    = cmd_cnt_q + LEN_W'(1);
    beat_d       = beat_cnt_q + (LEN_W+1)'(in_rd_c && app_rd_data_valid);
    beats_done_c = (beat_d == {1'b0, len_q});
  end

  // Burst sequencer: grant, issue commands, drain read beats, report done
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cmd_cnt_q  <= '0;
      beat_cnt_q <= '0;
      last_rd_q  <= 1'b1;
      is_rd_q    <= 1'b0;
      app_en_q   <= 1'b0;
      app_cmd_q  <= CMD_WR;
      wdf_q      <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else if (!init_calib_complete) begin
      // Calibration lost: abandon whatever was in flight without a done.
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cmd_cnt_q  <= '0;
      beat_cnt_q <= '0;
      app_en_q   <= 1'b0;
      app_cmd_q  <= CMD_WR;
      wdf_q      <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_wr_c) begin
            addr_q     <= wr_addr;
            len_q      <= wr_len;
            cmd_cnt_q  <= '0;
            beat_cnt_q <= '0;
            is_rd_q    <= 1'b0;
            app_cmd_q  <= CMD_WR;
            if (wr_len == '0) begin
              state_q   <= S_DONE;
              wr_done_q <= 1'b1;
            end else begin
              state_q  <= S_WR_BURST;
              app_en_q <= 1'b1;
              wdf_q    <= 1'b1;
            end
          end else if (grant_rd_c) begin
            addr_q     <= rd_addr;
            len_q      <= rd_len;
            cmd_cnt_q  <= '0;
            beat_cnt_q <= '0;
            is_rd_q    <= 1'b1;
            if (rd_len == '0) begin
              state_q   <= S_DONE;
              rd_done_q <= 1'b1;
            end else begin
              state_q   <= S_RD_BURST;
              app_en_q  <= 1'b1;
              app_cmd_q <= CMD_RD;
            end
          end
        end
        S_WR_BURST: begin
          if (wr_accept_c) begin
            addr_q    <= addr_d;
            cmd_cnt_q <= cmd_cnt_d;
            if (last_cmd_c) begin
              app_en_q  <= 1'b0;
              wdf_q     <= 1'b0;
              state_q   <= S_DONE;
              wr_done_q <= 1'b1;
            end
          end
        end
        S_RD_BURST: begin
          beat_cnt_q <= beat_d;
          if (rd_accept_c) begin
            addr_q    <= addr_d;
            cmd_cnt_q <= cmd_cnt_d;
            if (last_cmd_c) begin
              app_en_q  <= 1'b0;
              app_cmd_q <= CMD_WR;
              if (beats_done_c) begin
                state_q   <= S_DONE;
                rd_done_q <= 1'b1;
              end else begin
                state_q <= S_RD_DRAIN;
              end
            end
          end
        end
        S_RD_DRAIN: begin
          beat_cnt_q <= beat_d;
          if (beats_done_c) begin
            state_q   <= S_DONE;
            rd_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          last_rd_q <= is_rd_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Acks are same-cycle responses to the request; silenced while in reset.
  assign wr_ack       = grant_wr_c && rst_n;
  assign rd_ack       = grant_rd_c && rst_n;
  assign wr_done      = wr_done_q;
  assign rd_done      = rd_done_q;
  assign app_en       = app_en_q;
  assign app_cmd      = app_cmd_q;
  assign app_addr     = addr_q;
  assign app_wdf_wren = wdf_q;
  assign app_wdf_end  = wdf_q;
  assign rfifo_wren   = in_rd_c && app_rd_data_valid;
  assign busy         = (state_q != S_IDLE);

endmodule
